// File: rtl/mux10_rr_sched_if.sv
// Request/grant bundle between the requesters and the 10:1 mux scheduler.
// The master side drives enable and requests; the slave side returns grant, select and valid.
interface mux10_rr_sched_if #(
    parameter int unsigned N     = 10,
    parameter int unsigned SEL_W = 4
);
    logic             en;
    logic [N-1:0]     req;
    logic [N-1:0]     gnt;
    logic [SEL_W-1:0] s;
    logic             valid;

    modport master (
        output en,
        output req,
        input  gnt,
        input  s,
        input  valid
    );

    modport slave (
        input  en,
        input  req,
        output gnt,
        output s,
        output valid
    );
endinterface

// File: rtl/mux10_rr_sched.sv
// Round-robin scheduler sharing one 10:1 mux: registered one-hot grant, binary select
// and valid, with a bounded hold per owner and one dead cycle on every handover.
module mux10_rr_sched #(
    parameter int unsigned N        = 10,
    parameter int unsigned SEL_W    = 4,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    mux10_rr_sched_if.slave    bus
);
    localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_e;

    state_e            state_q;
    logic [N-1:0]      gnt_q;
    logic [SEL_W-1:0]  s_q;
    logic              valid_q;
    logic [HOLD_W-1:0] hold_q;
    logic [SEL_W-1:0]  ptr_q;

    logic [SEL_W-1:0]  pick_d;
    logic              found_d;
    int unsigned       idx;
    logic              own_req;
    logic              others_req;
    logic              hold_full;

    // Scan ptr+1, ptr+2, ... modulo N; the first requester reached wins.
    always_comb begin
        pick_d  = '0;
        found_d = 1'b0;
        idx     = 0;
        for (int unsigned k = 1; k <= N; k++) begin
            idx = 32'(ptr_q) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found_d && bus.req[SEL_W'(idx)]) begin
                pick_d  = SEL_W'(idx);
                found_d = 1'b1;
            end
        end
    end

    assign own_req    = |(bus.req & gnt_q);
    assign others_req = |(bus.req & ~gnt_q);
    assign hold_full  = (hold_q == HOLD_W'(MAX_HOLD));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            s_q     <= '0;
            valid_q <= 1'b0;
            hold_q  <= '0;
            ptr_q   <= SEL_W'(N - 1);
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.en && found_d) begin
                        state_q <= GRANT;
                        gnt_q   <= N'(1) << pick_d;
                        s_q     <= pick_d;
                        valid_q <= 1'b1;
                        hold_q  <= HOLD_W'(1);
                    end
                end
                GRANT: begin
                    if (!bus.en || !own_req || (hold_full && others_req)) begin
                        // S deliberately keeps the last owner after release.
                        state_q <= IDLE;
                        gnt_q   <= '0;
                        valid_q <= 1'b0;
                        ptr_q   <= s_q;
                    end else if (!hold_full) begin
                        hold_q <= hold_q + HOLD_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.gnt   = gnt_q;
    assign bus.s     = s_q;
    assign bus.valid = valid_q;
endmodule

// File: tb/tb_mux10_rr_sched.sv
// Randomised and directed stimulus for mux10_rr_sched; a behavioural model predicts each
// cycle's outputs into a queue that an independent monitor pops and compares.
module tb_mux10_rr_sched;
    localparam int NREQ = 10;
    localparam int HOLD = 8;

    typedef struct packed {
        logic [NREQ-1:0] gnt;
        logic [3:0]      s;
        logic            valid;
    } exp_t;

    logic clk;
    logic rst_n;
    mux10_rr_sched_if #(.N(NREQ), .SEL_W(4)) bus ();

    mux10_rr_sched #(.N(NREQ), .SEL_W(4), .MAX_HOLD(HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model state: who owns the mux, for how long, and who owned it last.
    bit busy;
    int owner, hold, last, sel;

    task automatic model_reset();
        busy = 0; owner = 0; hold = 0; last = NREQ - 1; sel = 0;
    endtask

    task automatic model_step(input bit en, input logic [NREQ-1:0] req);
        if (!busy) begin
            if (en) begin
                for (int k = 1; k <= NREQ; k++) begin
                    if (req[(last + k) % NREQ]) begin
                        busy = 1; owner = (last + k) % NREQ; sel = owner; hold = 1;
                        break;
                    end
                end
            end
        end else begin
            int competitors;
            competitors = 0;
            for (int i = 0; i < NREQ; i++)
                if (i != owner && req[i]) competitors++;
            if (!en || !req[owner] || (hold == HOLD && competitors > 0)) begin
                busy = 0; last = owner;
            end else if (hold < HOLD) begin
                hold++;
            end
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.gnt   = '0;
        if (busy) e.gnt[owner] = 1'b1;
        e.s     = 4'(sel);
        e.valid = busy;
        return e;
    endfunction

    // One clock of stimulus: inputs change on the falling edge, the rising edge consumes them.
    task automatic cycle(input bit rst, input bit en, input logic [NREQ-1:0] req);
        @(negedge clk);
        rst_n   = rst;
        bus.en  = en;
        bus.req = req;
        if (!rst) model_reset();
        else      model_step(en, req);
        exp_q.push_back(model_out());
    endtask

    task automatic check_now(input string name, input exp_t e);
        n_checks++;
        if ({bus.gnt, bus.s, bus.valid} !== e) begin
            n_errors++;
            $display("FAIL %s: got gnt=%h s=%0d valid=%b, expected gnt=%h s=%0d valid=%b",
                     name, bus.gnt, bus.s, bus.valid, e.gnt, e.s, e.valid);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: every output cycle is compared with the oldest prediction, plus the invariants.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                check_now("outputs", exp_q.pop_front());
                n_checks++;
                if (!$onehot0(bus.gnt) || (bus.valid !== (|bus.gnt)) || (bus.s >= 4'd10) ||
                    (bus.valid && bus.gnt !== (10'd1 << bus.s))) begin
                    n_errors++;
                    $display("FAIL invariant: gnt=%h s=%0d valid=%b", bus.gnt, bus.s, bus.valid);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NREQ-1:0] r;
        exp_t zero;
        zero  = '0;
        rst_n = 1'b0;
        bus.en  = 1'b1;
        bus.req = 10'h3FF;
        model_reset();

        // Reset with every request up, then idle while disabled.
        repeat (3) cycle(0, 1, 10'h3FF);
        check_now("reset_outputs", zero);
        repeat (4) cycle(1, 0, 10'h3FF);

        // Single requester, grant then drop.
        repeat (5) cycle(1, 1, 10'h008);
        repeat (3) cycle(1, 1, 10'h000);

        // Fairness from a fresh reset, then wrap-around with 0 and 9 competing.
        repeat (2) cycle(0, 1, 10'h000);
        repeat (9 * 11) cycle(1, 1, 10'h3FF);
        repeat (40) cycle(1, 1, 10'h201);

        // Hold limit: lone owner keeps the grant until a competitor shows up.
        repeat (2) cycle(1, 1, 10'h000);
        repeat (12) cycle(1, 1, 10'h004);
        repeat (20) cycle(1, 1, 10'h024);

        // Enable drop mid-grant, then asynchronous reset mid-grant.
        repeat (2) cycle(1, 1, 10'h000);
        repeat (4) cycle(1, 1, 10'h3FF);
        repeat (5) cycle(1, 0, 10'h3FF);
        repeat (4) cycle(1, 1, 10'h3FF);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_now("async_reset", zero);
        repeat (2) cycle(0, 1, 10'h3FF);
        repeat (12) cycle(1, 1, 10'h3FF);

        // Random traffic: requests are sticky levels that occasionally flip.
        r = '0;
        for (int c = 0; c < 500; c++) begin
            for (int b = 0; b < NREQ; b++)
                if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
            cycle(1, $urandom_range(0, 9) != 0, r);
        end

        @(posedge clk);
        #3;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: got %0d pending predictions, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
